// File: rtl/crop_pkg.sv
// Shared types and helpers for the crop frame sequencer.
package crop_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_DONE,
    DONE
  } seq_state_t;

  // Counter width for a dimension; never narrower than one bit.
  function automatic int unsigned col_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned row_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned clamp_coord(input int unsigned req, input int unsigned in_sz,
                                              input int unsigned out_sz);
    return (req + out_sz > in_sz) ? (in_sz - out_sz) : req;
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Raster position counter: column wraps into row, row wraps to zero after the last pixel.
module frame_pos_counter
  import crop_pkg::*;
#(
  parameter int unsigned COLS = 20,
  parameter int unsigned ROWS = 20
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    clr,
  input  logic                    en,
  output logic [col_w(COLS)-1:0]  col,
  output logic [row_w(ROWS)-1:0]  row,
  output logic                    last
);

  localparam int unsigned CW = col_w(COLS);
  localparam int unsigned RW = row_w(ROWS);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end, row_end;

  assign col_end = (col_q == CW'(COLS - 1));
  assign row_end = (row_q == RW'(ROWS - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/crop_frame_sequencer.sv
// Frame-level controller for the crop datapath: start/done handshake, raster position, window check.
// Define CROP_CLAMP_EN to clamp out-of-range crop coordinates when they are latched.
module crop_frame_sequencer
  import crop_pkg::*;
#(
  parameter int unsigned IN_ROWS  = 20,
  parameter int unsigned IN_COLS  = 20,
  parameter int unsigned OUT_ROWS = 10,
  parameter int unsigned OUT_COLS = 10,
  parameter int unsigned FCNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic [col_w(IN_COLS)-1:0]  crop_x0_in,
  input  logic [row_w(IN_ROWS)-1:0]  crop_y0_in,
  output logic [col_w(IN_COLS)-1:0]  crop_x0,
  output logic [row_w(IN_ROWS)-1:0]  crop_y0,
  output logic                       gate_open,
  input  logic                       beat,
  output logic [col_w(IN_COLS)-1:0]  cnt_col,
  output logic [row_w(IN_ROWS)-1:0]  cnt_row,
  input  logic                       cf_ap_done,
  output logic [FCNT_W-1:0]          frame_cnt,
  output logic                       cfg_err
);

  localparam int unsigned COL_W = col_w(IN_COLS);
  localparam int unsigned ROW_W = row_w(IN_ROWS);

  seq_state_t        state_q, state_d;
  logic [COL_W-1:0]  crop_x0_q, crop_x0_d;
  logic [ROW_W-1:0]  crop_y0_q, crop_y0_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cf_seen_q, cf_seen_d;
  logic              gate_open_q, gate_open_d;
  logic              ap_done_q, ap_done_d;
  logic              idle_q, idle_d;

  logic              start_acc;
  logic              cnt_en;
  logic              cnt_last;
  logic [COL_W:0]    x_sum;
  logic [ROW_W:0]    y_sum;
  logic              x_err, y_err;
  logic [COL_W-1:0]  x_lat;
  logic [ROW_W-1:0]  y_lat;

  // One extra bit so the window end cannot wrap.
  assign x_sum = {1'b0, crop_x0_in} + (COL_W + 1)'(OUT_COLS);
  assign y_sum = {1'b0, crop_y0_in} + (ROW_W + 1)'(OUT_ROWS);
  assign x_err = (x_sum > (COL_W + 1)'(IN_COLS));
  assign y_err = (y_sum > (ROW_W + 1)'(IN_ROWS));

`ifdef CROP_CLAMP_EN
  assign x_lat = COL_W'(clamp_coord(32'(crop_x0_in), IN_COLS, OUT_COLS));
  assign y_lat = ROW_W'(clamp_coord(32'(crop_y0_in), IN_ROWS, OUT_ROWS));
`else
  assign x_lat = crop_x0_in;
  assign y_lat = crop_y0_in;
`endif

  frame_pos_counter #(
    .COLS (IN_COLS),
    .ROWS (IN_ROWS)
  ) u_pos (
    .clk  (clk),
    .srst (srst),
    .clr  (start_acc),
    .en   (cnt_en),
    .col  (cnt_col),
    .row  (cnt_row),
    .last (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    crop_x0_d   = crop_x0_q;
    crop_y0_d   = crop_y0_q;
    frame_cnt_d = frame_cnt_q;
    cfg_err_d   = cfg_err_q;
    cf_seen_d   = cf_seen_q;
    start_acc   = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cf_seen_d = 1'b0;
        if (ap_start) begin
          start_acc = 1'b1;
          crop_x0_d = x_lat;
          crop_y0_d = y_lat;
          cfg_err_d = x_err || y_err;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        cnt_en    = beat;
        cf_seen_d = cf_seen_q || cf_ap_done;
        // A crop-stage done seen on or before the last beat skips WAIT_DONE.
        if (beat && cnt_last) begin
          state_d = cf_seen_d ? DONE : WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cf_seen_d = cf_seen_q || cf_ap_done;
        if (cf_seen_d) begin
          state_d = DONE;
        end
      end
      DONE: begin
        cf_seen_d   = 1'b0;
        frame_cnt_d = frame_cnt_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    gate_open_d = (state_d == STREAM);
    ap_done_d   = (state_d == DONE);
    idle_d      = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      crop_x0_q   <= '0;
      crop_y0_q   <= '0;
      frame_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
      cf_seen_q   <= 1'b0;
      gate_open_q <= 1'b0;
      ap_done_q   <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      crop_x0_q   <= crop_x0_d;
      crop_y0_q   <= crop_y0_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_err_q   <= cfg_err_d;
      cf_seen_q   <= cf_seen_d;
      gate_open_q <= gate_open_d;
      ap_done_q   <= ap_done_d;
      idle_q      <= idle_d;
    end
  end

  assign ap_idle   = idle_q;
  assign ap_ready  = idle_q;
  assign ap_done   = ap_done_q;
  assign gate_open = gate_open_q;
  assign crop_x0   = crop_x0_q;
  assign crop_y0   = crop_y0_q;
  assign frame_cnt = frame_cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule
